// File: rtl/exe_pkg.sv
// Shared types for the execute stage: ALU opcodes, multiply FSM states, multiply length.
`timescale 1ns/1ps
package exe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_MUL   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} exe_state_e;

    localparam int unsigned MUL_CYCLES = 16;
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
// Only instantiated when EXE_MUL_EN is defined.
`timescale 1ns/1ps
module exe_mul_seq
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    exe_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution and EX/MEM register. Define EXE_MUL_EN to
// compile in the 16-cycle iterative multiplier that stalls upstream while busy.
`timescale 1ns/1ps
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] pc_plus2_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [DATA_W-1:0] extend_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regWrite_i,
    input  logic              memWrite_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              aluSrc_i,
    input  logic [1:0]        resultSrc_i,
    input  logic [3:0]        aluControl_i,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_target_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic [DATA_W-1:0] pc_plus2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              regWrite_o,
    output logic              memWrite_o,
    output logic [1:0]        resultSrc_o
);

    logic [DATA_W-1:0] op_a, op_b, alu_res, mul_prod;
    logic [3:0]        shamt;
    logic              zero, mul_done, fsm_hold;

    assign op_a  = op1_i;
    assign op_b  = aluSrc_i ? extend_i : op2_i;
    assign shamt = op_b[3:0];

    // MUL is not computed here; it falls to the zero default like any undefined op.
    always_comb begin
        alu_res = '0;
        case (aluControl_i)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

`ifdef EXE_MUL_EN
    logic is_mul, mul_busy, mul_start;

    assign is_mul    = (aluControl_i == ALU_MUL);
    // Only accept from IDLE so the held MUL instruction cannot restart the sequence.
    assign mul_start = is_mul & ~mul_busy & ~mul_done;
    assign stall_o   = mul_busy | (reset & mul_start);
    assign zero      = (alu_res == '0) & ~is_mul;
    assign fsm_hold  = mul_busy | mul_done;

    exe_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign stall_o  = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
    assign zero     = (alu_res == '0);
    assign fsm_hold = 1'b0;
`endif

    assign pc_src_o    = ~fsm_hold & (jump_i | (branch_i & zero));
    assign pc_target_o = pc_i + extend_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_o <= '0;
            write_data_o <= '0;
            pc_plus2_o   <= '0;
            rd_o         <= '0;
            regWrite_o   <= 1'b0;
            memWrite_o   <= 1'b0;
            resultSrc_o  <= '0;
        end else if (stall_o) begin
            alu_result_o <= '0;
            write_data_o <= '0;
            pc_plus2_o   <= '0;
            rd_o         <= '0;
            regWrite_o   <= 1'b0;
            memWrite_o   <= 1'b0;
            resultSrc_o  <= '0;
        end else begin
            alu_result_o <= mul_done ? mul_prod : alu_res;
            write_data_o <= op2_i;
            pc_plus2_o   <= pc_plus2_i;
            rd_o         <= rd_i;
            regWrite_o   <= regWrite_i;
            memWrite_o   <= memWrite_i;
            resultSrc_o  <= resultSrc_i;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; multiply checks follow EXE_MUL_EN.
`timescale 1ns/1ps
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_i, pc_plus2_i, op1_i, op2_i, extend_i;
    logic [3:0]  rd_i;
    logic        regWrite_i, memWrite_i, jump_i, branch_i, aluSrc_i;
    logic [1:0]  resultSrc_i;
    logic [3:0]  aluControl_i;
    logic        pc_src_o, stall_o, regWrite_o, memWrite_o;
    logic [15:0] pc_target_o, alu_result_o, write_data_o, pc_plus2_o;
    logic [3:0]  rd_o;
    logic [1:0]  resultSrc_o;

    int checks   = 0;
    int failures = 0;

    exe_stage #(
        .DATA_W (16),
        .REG_AW (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (pc_i),
        .pc_plus2_i   (pc_plus2_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .extend_i     (extend_i),
        .rd_i         (rd_i),
        .regWrite_i   (regWrite_i),
        .memWrite_i   (memWrite_i),
        .jump_i       (jump_i),
        .branch_i     (branch_i),
        .aluSrc_i     (aluSrc_i),
        .resultSrc_i  (resultSrc_i),
        .aluControl_i (aluControl_i),
        .pc_src_o     (pc_src_o),
        .pc_target_o  (pc_target_o),
        .stall_o      (stall_o),
        .alu_result_o (alu_result_o),
        .write_data_o (write_data_o),
        .pc_plus2_o   (pc_plus2_o),
        .rd_o         (rd_o),
        .regWrite_o   (regWrite_o),
        .memWrite_o   (memWrite_o),
        .resultSrc_o  (resultSrc_o)
    );

    always #5 clk = ~clk;

    // ctl, op1, op2, aluSrc, extend, expected result
    localparam int NV = 13;
    localparam logic [3:0]  V_CTL [NV] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                           4'h6, 4'h7, 4'h8, 4'h8, 4'hA, 4'hF};
    localparam logic [15:0] V_A   [NV] = '{16'h0003, 16'hFFFF, 16'h0005, 16'hF0F0, 16'hF0F0,
                                           16'hF0F0, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF,
                                           16'h0001, 16'h1111, 16'h1234};
    localparam logic [15:0] V_B   [NV] = '{16'h0004, 16'h0002, 16'h0007, 16'h0FF0, 16'h0FF0,
                                           16'h0FF0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                                           16'hFFFF, 16'h0000, 16'h5678};
    localparam logic        V_SRC [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                           1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] V_EXT [NV] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                           16'h0000, 16'h000F, 16'h0004, 16'h0004, 16'h0000,
                                           16'h0000, 16'hABCD, 16'h0000};
    localparam logic [15:0] V_EXP [NV] = '{16'h0007, 16'h0001, 16'hFFFE, 16'h00F0, 16'hFFF0,
                                           16'hFF00, 16'h8000, 16'h0800, 16'hF800, 16'h0001,
                                           16'h0000, 16'hABCD, 16'h0000};

    task automatic set_defaults();
        pc_i = '0; pc_plus2_i = '0; op1_i = '0; op2_i = '0; extend_i = '0; rd_i = '0;
        regWrite_i = 0; memWrite_i = 0; jump_i = 0; branch_i = 0; aluSrc_i = 0;
        resultSrc_i = '0; aluControl_i = 4'h0;
    endtask

    task automatic test_reset();
        set_defaults();
        reset = 1'b0;
        #3;
        checks++;
        if ({alu_result_o, write_data_o, pc_plus2_o} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got %h/%h/%h want 0", alu_result_o, write_data_o,
                     pc_plus2_o);
        end
        checks++;
        if ({rd_o, regWrite_o, memWrite_o, resultSrc_o, stall_o} !== 9'h0) begin
            failures++;
            $display("FAIL reset_ctrl got rd=%h rw=%b mw=%b rs=%h st=%b want 0", rd_o,
                     regWrite_o, memWrite_o, resultSrc_o, stall_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'h0 || regWrite_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got res=%h rw=%b want 0000/0", alu_result_o, regWrite_o);
        end
    endtask

    task automatic test_alu_ops();
        for (int i = 0; i < NV; i++) begin
            set_defaults();
            aluControl_i = V_CTL[i]; op1_i = V_A[i]; op2_i = V_B[i];
            aluSrc_i = V_SRC[i]; extend_i = V_EXT[i];
            regWrite_i = 1'b1; rd_i = 4'(i);
            #1;
            checks++;
            if (stall_o !== 1'b0) begin
                failures++;
                $display("FAIL alu%0d_stall got %b want 0", i, stall_o);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_result_o !== V_EXP[i]) begin
                failures++;
                $display("FAIL alu%0d_result ctl=%h got %h want %h", i, V_CTL[i],
                         alu_result_o, V_EXP[i]);
            end
            checks++;
            if (regWrite_o !== 1'b1 || rd_o !== 4'(i)) begin
                failures++;
                $display("FAIL alu%0d_ctrl got rw=%b rd=%h want 1/%h", i, regWrite_o, rd_o,
                         4'(i));
            end
        end
    endtask

    task automatic test_branch();
        set_defaults();
        aluControl_i = 4'h1; branch_i = 1'b1;
        op1_i = 16'h1234; op2_i = 16'h1234; pc_i = 16'h0040; extend_i = 16'hFFF8;
        #1;
        checks++;
        if (pc_src_o !== 1'b1 || pc_target_o !== 16'h0038) begin
            failures++;
            $display("FAIL branch_taken got src=%b tgt=%h want 1/0038", pc_src_o, pc_target_o);
        end
        op2_i = 16'h1235;
        #1;
        checks++;
        if (pc_src_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_not_taken got src=%b want 0", pc_src_o);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL branch_sub got %h want ffff", alu_result_o);
        end
        branch_i = 1'b0; jump_i = 1'b1; pc_i = 16'hFFF0; extend_i = 16'h0020;
        #1;
        checks++;
        if (pc_src_o !== 1'b1 || pc_target_o !== 16'h0010) begin
            failures++;
            $display("FAIL jump got src=%b tgt=%h want 1/0010", pc_src_o, pc_target_o);
        end
    endtask

    task automatic test_store();
        set_defaults();
        aluControl_i = 4'h0; aluSrc_i = 1'b1; op1_i = 16'h0100; op2_i = 16'h5555;
        extend_i = 16'h0004; memWrite_i = 1'b1; resultSrc_i = 2'b10;
        pc_plus2_i = 16'h0042; rd_i = 4'hA;
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'h0104 || write_data_o !== 16'h5555) begin
            failures++;
            $display("FAIL store_data got res=%h wd=%h want 0104/5555", alu_result_o,
                     write_data_o);
        end
        checks++;
        if (memWrite_o !== 1'b1 || regWrite_o !== 1'b0 || resultSrc_o !== 2'b10) begin
            failures++;
            $display("FAIL store_flags got mw=%b rw=%b rs=%b want 1/0/10", memWrite_o,
                     regWrite_o, resultSrc_o);
        end
        checks++;
        if (pc_plus2_o !== 16'h0042 || rd_o !== 4'hA) begin
            failures++;
            $display("FAIL store_pass got pc2=%h rd=%h want 0042/a", pc_plus2_o, rd_o);
        end
    endtask

    task automatic test_reset_mid_alu();
        set_defaults();
        op1_i = 16'h0003; op2_i = 16'h0004; regWrite_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (alu_result_o !== 16'h0 || regWrite_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got res=%h rw=%b want 0000/0", alu_result_o, regWrite_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'h0007) begin
            failures++;
            $display("FAIL after_reset_add got %h want 0007", alu_result_o);
        end
    endtask

`ifdef EXE_MUL_EN
    localparam logic [15:0] M_A   [3] = '{16'h0012, 16'h0100, 16'hFFFF};
    localparam logic [15:0] M_B   [3] = '{16'h0034, 16'h0100, 16'hFFFF};
    localparam logic [15:0] M_EXP [3] = '{16'h03A8, 16'h0000, 16'h0001};

    // Operands are swapped in immediately after each DONE edge: back-to-back MULs.
    task automatic test_back_to_back_mul();
        set_defaults();
        for (int m = 0; m < 3; m++) begin
            int cnt = 0;
            int bad = 0;
            aluControl_i = 4'h9; op1_i = M_A[m]; op2_i = M_B[m];
            regWrite_i = 1'b1; branch_i = 1'b1; rd_i = 4'h3;
            #1;
            for (int c = 0; c < 40 && stall_o === 1'b1; c++) begin
                cnt++;
                if (pc_src_o !== 1'b0) bad++;
                if (c > 0 && (regWrite_o !== 1'b0 || alu_result_o !== 16'h0)) bad++;
                @(posedge clk); #1;
            end
            checks++;
            if (cnt != 17) begin
                failures++;
                $display("FAIL mul%0d_stall_cycles got %0d want 17", m, cnt);
            end
            checks++;
            if (bad != 0 || regWrite_o !== 1'b0 || pc_src_o !== 1'b0) begin
                failures++;
                $display("FAIL mul%0d_bubbles got %0d bad cycles, rw=%b src=%b want 0/0/0",
                         m, bad, regWrite_o, pc_src_o);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_result_o !== M_EXP[m] || regWrite_o !== 1'b1 || rd_o !== 4'h3) begin
                failures++;
                $display("FAIL mul%0d_result got %h rw=%b rd=%h want %h/1/3", m, alu_result_o,
                         regWrite_o, rd_o, M_EXP[m]);
            end
        end
        set_defaults();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        set_defaults();
        aluControl_i = 4'h9; op1_i = 16'h0012; op2_i = 16'h0034; regWrite_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || alu_result_o !== 16'h0 || regWrite_o !== 1'b0) begin
            failures++;
            $display("FAIL mul_reset got st=%b res=%h rw=%b want 0/0000/0", stall_o,
                     alu_result_o, regWrite_o);
        end
        aluControl_i = 4'h0; op1_i = 16'h0003; op2_i = 16'h0004;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'h0007 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL mul_reset_add got res=%h st=%b want 0007/0", alu_result_o, stall_o);
        end
    endtask
`else
    task automatic test_mul_disabled();
        set_defaults();
        aluControl_i = 4'h9; op1_i = 16'h0012; op2_i = 16'h0034; regWrite_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL nomul_stall got %b want 0", stall_o);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_result_o !== 16'h0 || regWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL nomul_result got %h rw=%b want 0000/1", alu_result_o, regWrite_o);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_o !== 1'b0 || regWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL nomul_hold got st=%b rw=%b want 0/1", stall_o, regWrite_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_store();
        test_reset_mid_alu();
`ifdef EXE_MUL_EN
        test_back_to_back_mul();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
